// File: rtl/pattern_scan_pkg.sv
// -----------------------------------------------------------------------------
// pattern_scan_pkg
// Shared types and constants for the bit-serial pattern scanner.
//   state_e    : controller states IDLE / SHIFT / DONE
//   PATTERN_W  : width of the detected pattern (3 bits, bit 2 oldest)
//   FILL_SAT   : saturation value of the history fill counter
// -----------------------------------------------------------------------------
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int         PATTERN_W = 3;
    localparam logic [1:0] FILL_SAT  = 2'd3;

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// pattern_scan_ctrl_if
// Groups the word-input and result handshakes of pattern_scan_ctrl.
//   cfg_pattern : pattern to detect, sampled on word accept
//   in_valid / in_ready / in_data    : word input handshake
//   out_valid / out_ready / out_count : result handshake
//   hit         : one-cycle pulse per matching bit
// Modports: master (producer/consumer side), slave (the scanner).
// -----------------------------------------------------------------------------
import pattern_scan_pkg::*;

interface pattern_scan_ctrl_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) ();
    logic [PATTERN_W-1:0] cfg_pattern;
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_W-1:0]    in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNT_W-1:0]     out_count;
    logic                 hit;

    modport master (
        output cfg_pattern, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count, hit
    );

    modport slave (
        input  cfg_pattern, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count, hit
    );
endinterface

// File: rtl/pattern_match_core.sv
// -----------------------------------------------------------------------------
// pattern_match_core
// Bit-serial 3-bit pattern detector with history and fill tracking.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : clears history and fill counter (word start)
//   shift_en   : a new bit is presented on bit_in this cycle
//   bit_in     : incoming bit (newest)
//   pattern    : pattern to match, bit 2 is the oldest bit
//   match      : combinational, high when the window ending at bit_in matches
// -----------------------------------------------------------------------------
module pattern_match_core
    import pattern_scan_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic                 bit_in,
    input  logic [PATTERN_W-1:0] pattern,
    output logic                 match
);

    // The newest bit of the 3-bit window arrives live on bit_in, so only the
    // two older bits need storing.
    logic [PATTERN_W-2:0] hist_q;
    logic [1:0]           fill_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_en) begin
            hist_q <= {hist_q[0], bit_in};
            if (fill_q != FILL_SAT) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end

    // A match needs two real bits of history before the incoming one.
    assign match = shift_en && (fill_q >= 2'd2) && ({hist_q, bit_in} == pattern);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_scan_ctrl
// Accepts a word, shifts it MSB-first through pattern_match_core one bit per
// clock, counts (saturating) the overlapping matches and returns the count.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : pattern_scan_ctrl_if.slave (word in, result out, hit pulse)
// Parameters: WORD_W (3..32) word width, CNT_W count width.
// Build option: define CARRY_HIST_EN to keep the match history across words,
// so matches spanning a word boundary count in the later word.
// -----------------------------------------------------------------------------
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pattern_scan_ctrl_if.slave   bus
);

    localparam int               BC_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e               state_q;
    logic [WORD_W-1:0]    shift_q;
    logic [BC_W-1:0]      bitcnt_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [PATTERN_W-1:0] pat_q;
    logic                 in_ready_q;
    logic                 out_valid_q;

    logic accept;
    logic core_clear;
    logic match;

    assign accept = in_ready_q && bus.in_valid;

`ifdef CARRY_HIST_EN
    // History survives across words; only reset clears it.
    assign core_clear = 1'b0;
`else
    assign core_clear = accept;
`endif

    pattern_match_core u_core (
        .clk      (clk),
        .reset    (reset),
        .clear    (core_clear),
        .shift_en (state_q == SHIFT),
        .bit_in   (shift_q[WORD_W-1]),
        .pattern  (pat_q),
        .match    (match)
    );

    // Count holds at its maximum; hit keeps pulsing regardless.
    assign cnt_d = (match && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            cnt_q       <= '0;
            pat_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q    <= bus.in_data;
                        pat_q      <= bus.cfg_pattern;
                        bitcnt_q   <= BC_W'(WORD_W - 1);
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_q <= {shift_q[WORD_W-2:0], 1'b0};
                    cnt_q   <= cnt_d;
                    if (bitcnt_q == '0) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        bitcnt_q <= bitcnt_q - 1'b1;
                    end
                end
                DONE: begin
                    // No skid buffer: the next word waits until the result is taken.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = cnt_q;
    assign bus.hit       = match;

endmodule
